// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding, one-hot verdict constants and default sizing.
package sar_pkg;

    localparam int SAR_WIDTH_DEF   = 8;
    localparam int SAR_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } sar_state_e;

    // Verdict vector ordering is {lt, eq, gt}; a well-formed verdict is one-hot.
    localparam logic [2:0] VERDICT_LT = 3'b100;
    localparam logic [2:0] VERDICT_EQ = 3'b010;
    localparam logic [2:0] VERDICT_GT = 3'b001;

    function automatic logic verdict_onehot(input logic [2:0] v);
        return (v == VERDICT_LT) || (v == VERDICT_EQ) || (v == VERDICT_GT);
    endfunction

endpackage

// File: rtl/sar_step.sv
// One successive-approximation step: given the accumulated bits, the bit
// under test and a verdict, produce the next accumulator, the next trial
// and whether the search terminates (with a hit or a failure).
module sar_step
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [IDX_W-1:0] idx,
    input  logic             lt,
    input  logic             eq,
    input  logic             gt,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] trial_next,
    output logic             terminal,
    output logic             hit,
    output logic             fail
);

    logic [WIDTH-1:0] bit_cur;
    logic [WIDTH-1:0] bit_nxt;
    logic             malformed;
    logic             last;

    // Trial below target keeps the bit; above target leaves it clear.
    always_comb begin
        bit_cur    = WIDTH'(1) << idx;
        bit_nxt    = WIDTH'(1) << (idx - IDX_W'(1));
        malformed  = !verdict_onehot({lt, eq, gt});
        last       = (idx == '0);
        acc_next   = lt ? (acc | bit_cur) : acc;
        // Only meaningful when not on the last bit; the wrap at idx==0 is unused.
        trial_next = acc_next | bit_nxt;
        terminal   = malformed || eq || last;
        // An lt/gt on the last bit is only consistent for a zero target.
        hit        = !malformed && (eq || (last && (acc_next == '0)));
        fail       = malformed || (!eq && last && (acc_next != '0));
    end

endmodule

// File: rtl/sar_search_8bit.sv
// Successive-approximation search initiator. Presents MSB-first trial values
// over a valid/valid handshake and consumes lt/eq/gt verdicts until the
// target is found or the verdict stream is inconsistent.
// Optional build macro SAR_TIMEOUT_EN: abort a probe after TIMEOUT_CYCLES
// cycles without a verdict.
module sar_search_8bit
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF,
    parameter int CNT_W = 4
`ifdef SAR_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = SAR_TIMEOUT_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    output logic             trial_valid,
    input  logic             res_valid,
    input  logic             res_lt,
    input  logic             res_eq,
    input  logic             res_gt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] value,
    output logic             found,
    output logic             err,
    output logic [CNT_W-1:0] probes
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic             trial_valid_q, trial_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] probes_q, probes_d;

`ifdef SAR_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    logic [WIDTH-1:0] step_acc_next;
    logic [WIDTH-1:0] step_trial_next;
    logic             step_terminal;
    logic             step_hit;
    logic             step_fail;
    logic             accept;

    sar_step #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_step (
        .acc        (acc_q),
        .idx        (idx_q),
        .lt         (res_lt),
        .eq         (res_eq),
        .gt         (res_gt),
        .acc_next   (step_acc_next),
        .trial_next (step_trial_next),
        .terminal   (step_terminal),
        .hit        (step_hit),
        .fail       (step_fail)
    );

    assign accept = trial_valid_q && res_valid;

    // Next-state and next-output computation for the search FSM.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        trial_d       = trial_q;
        trial_valid_d = trial_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        value_d       = value_q;
        found_d       = found_q;
        err_d         = err_q;
        probes_d      = probes_q;
`ifdef SAR_TIMEOUT_EN
        wait_d        = wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d         = '0;
                    value_d       = '0;
                    found_d       = 1'b0;
                    err_d         = 1'b0;
                    probes_d      = '0;
                    idx_d         = IDX_W'(WIDTH - 1);
                    trial_d       = WIDTH'(1) << (WIDTH - 1);
                    trial_valid_d = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = ST_PROBE;
`ifdef SAR_TIMEOUT_EN
                    wait_d        = '0;
`endif
                end
            end
            ST_PROBE: begin
                if (accept) begin
                    probes_d = probes_q + CNT_W'(1);
                    acc_d    = step_acc_next;
                    if (step_terminal) begin
                        state_d       = ST_DONE;
                        done_d        = 1'b1;
                        busy_d        = 1'b0;
                        trial_valid_d = 1'b0;
                        found_d       = step_hit;
                        err_d         = step_fail;
                        value_d       = (step_hit && res_eq) ? trial_q : '0;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        trial_d = step_trial_next;
`ifdef SAR_TIMEOUT_EN
                        wait_d  = '0;
`endif
                    end
                end
`ifdef SAR_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = ST_DONE;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    trial_valid_d = 1'b0;
                    found_d       = 1'b0;
                    err_d         = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset aborts any search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            idx_q         <= IDX_W'(WIDTH - 1);
            trial_q       <= '0;
            trial_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            value_q       <= '0;
            found_q       <= 1'b0;
            err_q         <= 1'b0;
            probes_q      <= '0;
`ifdef SAR_TIMEOUT_EN
            wait_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            trial_q       <= trial_d;
            trial_valid_q <= trial_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            value_q       <= value_d;
            found_q       <= found_d;
            err_q         <= err_d;
            probes_q      <= probes_d;
`ifdef SAR_TIMEOUT_EN
            wait_q        <= wait_d;
`endif
        end
    end

    assign trial       = trial_q;
    assign trial_valid = trial_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign value       = value_q;
    assign found       = found_q;
    assign err         = err_q;
    assign probes      = probes_q;

endmodule

// File: tb/tb_sar_search_8bit.sv
// Self-checking bench for sar_search_8bit: a behavioural compare responder
// with configurable latency and fault injection, checked against a model
// that derives trials, results and probe counts from the target directly.
// Honours SAR_TIMEOUT_EN for the no-response scenario.
module tb_sar_search_8bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] trial;
    logic       trial_valid;
    logic       res_valid;
    logic       res_lt;
    logic       res_eq;
    logic       res_gt;
    logic       busy;
    logic       done;
    logic [7:0] value;
    logic       found;
    logic       err;
    logic [3:0] probes;

    int errors = 0;
    int checks = 0;
    logic [7:0] trial_log[$];

    sar_search_8bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .trial       (trial),
        .trial_valid (trial_valid),
        .res_valid   (res_valid),
        .res_lt      (res_lt),
        .res_eq      (res_eq),
        .res_gt      (res_gt),
        .busy        (busy),
        .done        (done),
        .value       (value),
        .found       (found),
        .err         (err),
        .probes      (probes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of probes a binary search needs: stops at the lowest set bit.
    function automatic int model_probes(input logic [7:0] t);
        if (t == 8'h00) return 8;
        for (int b = 0; b < 8; b++) if (t[b]) return 8 - b;
        return 8;
    endfunction

    // Trial offered at probe k: target bits above the tested bit, plus that bit.
    function automatic logic [7:0] model_trial(input logic [7:0] t, input int k);
        int idx;
        int mask;
        idx  = 7 - k;
        mask = (32'hFF << (idx + 1)) & 32'hFF;
        return 8'((int'(t) & mask) | (1 << idx));
    endfunction

    // Drive one complete search against a responder holding tgt.
    task automatic run_search(input logic [7:0] tgt, input int lat, input int bad_probe,
                              input bit poke_start, input string name);
        int waitc;
        int k;
        bit fin;
        logic [7:0] held;
        int exp_probes;
        logic [7:0] exp_value;
        logic exp_found;
        logic exp_err;

        exp_probes = model_probes(tgt);
        if (bad_probe > 0 && bad_probe <= exp_probes) begin
            exp_probes = bad_probe; exp_value = 8'h00; exp_found = 1'b0; exp_err = 1'b1;
        end else begin
            exp_value = tgt; exp_found = 1'b1; exp_err = 1'b0;
        end

        trial_log.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if ({found, err, probes, value} !== 14'd0) begin
            errors++;
            $display("FAIL %s start_clear: found=%0b err=%0b probes=%0d value=%02h, required all zero",
                     name, found, err, probes, value);
        end

        waitc = 0; k = 0; fin = 1'b0; held = 8'h00;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            res_valid = 1'b0; res_lt = 1'b0; res_eq = 1'b0; res_gt = 1'b0; start = 1'b0;
            if (done) begin
                fin = 1'b1;
            end else if (trial_valid) begin
                if (waitc == 0) begin
                    trial_log.push_back(trial);
                    checks++;
                    if (trial !== model_trial(tgt, k)) begin
                        errors++;
                        $display("FAIL %s trial%0d: got %02h, required %02h", name, k, trial, model_trial(tgt, k));
                    end
                end else if (trial !== held) begin
                    checks++;
                    errors++;
                    $display("FAIL %s trial_stable: got %02h, required %02h", name, trial, held);
                end
                held = trial;
                if (waitc >= lat) begin
                    res_valid = 1'b1;
                    if (k + 1 == bad_probe) begin
                        res_lt = 1'b1; res_gt = 1'b1;
                    end else begin
                        res_lt = (trial < tgt);
                        res_eq = (trial == tgt);
                        res_gt = (trial > tgt);
                    end
                    k++;
                    waitc = 0;
                end else begin
                    waitc++;
                end
                if (poke_start && (cyc % 2 == 1)) start = 1'b1;
            end
            if (!fin) @(negedge clk);
        end

        if (!fin) begin
            checks++; errors++;
            $display("FAIL %s timeout: no done within 200 cycles, required done", name);
            return;
        end

        checks++;
        if ({value, found, err, probes, busy, trial_valid} !==
            {exp_value, exp_found, exp_err, 4'(exp_probes), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s result: value=%02h found=%0b err=%0b probes=%0d busy=%0b tv=%0b, required value=%02h found=%0b err=%0b probes=%0d busy=0 tv=0",
                     name, value, found, err, probes, busy, trial_valid,
                     exp_value, exp_found, exp_err, exp_probes);
        end else begin
            $display("search %s target=%02h lat=%0d -> value=%02h found=%0b err=%0b probes=%0d",
                     name, tgt, lat, value, found, err, probes);
        end

        @(negedge clk);
        checks++;
        if ({done, value, found, err} !== {1'b0, exp_value, exp_found, exp_err}) begin
            errors++;
            $display("FAIL %s after_done: done=%0b value=%02h found=%0b err=%0b, required done=0 held result",
                     name, done, value, found, err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        res_valid = 1'b0; res_lt = 1'b0; res_eq = 1'b0; res_gt = 1'b0;
        #22;
        checks++;
        if ({trial, trial_valid, busy, done, value, found, err, probes} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state: got %h, required 0",
                     {trial, trial_valid, busy, done, value, found, err, probes});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, trial_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: busy=%0b done=%0b tv=%0b, required 0", busy, done, trial_valid);
        end
        $display("reset checked");
    endtask

    task automatic test_directed();
        logic [7:0] exp_seq [8];
        exp_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        run_search(8'hA5, 0, 0, 1'b0, "a5");
        checks++;
        if (trial_log.size() != 8) begin
            errors++;
            $display("FAIL a5_seq_len: got %0d, required 8", trial_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (trial_log[i] !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL a5_seq%0d: got %02h, required %02h", i, trial_log[i], exp_seq[i]);
                end
            end
        end
        run_search(8'h80, 0, 0, 1'b0, "80");
        run_search(8'h00, 0, 0, 1'b0, "00");
        run_search(8'hFF, 0, 0, 1'b0, "ff");
        run_search(8'h01, 0, 0, 1'b0, "01");
    endtask

    task automatic test_malformed();
        run_search(8'h5A, 0, 3, 1'b0, "bad3");
        run_search(8'h5A, 0, 0, 1'b0, "after_bad");
    endtask

    task automatic test_latency();
        run_search(8'h3C, 3, 0, 1'b1, "lat3");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] t;
            t = 8'($urandom_range(0, 255));
            run_search(t, int'($urandom_range(0, 2)), 0, 1'b1, $sformatf("rnd%0d", i));
        end
    endtask

    task automatic test_midreset();
        bit saw_done;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({trial, trial_valid, busy, done, value, found, err, probes} !== 26'd0) begin
            errors++;
            $display("FAIL midreset_state: got %h, required 0",
                     {trial, trial_valid, busy, done, value, found, err, probes});
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midreset_quiet: done/busy seen after abort, required none");
        end
        $display("midreset checked");
    endtask

    task automatic test_no_response();
        int n;
        res_valid = 1'b0; res_lt = 1'b0; res_eq = 1'b0; res_gt = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (n < 40 && !done) begin
            @(negedge clk);
            n++;
        end
`ifdef SAR_TIMEOUT_EN
        checks++;
        if (n != 15 || err !== 1'b1 || found !== 1'b0) begin
            errors++;
            $display("FAIL timeout: done after %0d cycles err=%0b found=%0b, required 15 cycles err=1 found=0",
                     n, err, found);
        end
        @(negedge clk);
`else
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || trial_valid !== 1'b1) begin
            errors++;
            $display("FAIL no_response_wait: done=%0b busy=%0b tv=%0b after %0d cycles, required busy=1 done=0",
                     done, busy, trial_valid, n);
        end
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
`endif
        $display("no-response checked after %0d cycles", n);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_malformed();
        test_latency();
        test_random();
        test_midreset();
        test_no_response();
        run_search(8'h42, 1, 0, 1'b0, "final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
